sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-port 32-bit to 16-bit SDRAM arbiter: each grant is served as a low then a high halfword access.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; fixed priority (P0 first) otherwise.
module sdram_arbiter #(
  parameter int TIMEOUT_CYC        = 1024,
  parameter int USER_ADDRESS_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          re_P0,
  input  logic                          we_P0,
  input  logic [31:0]                   addr_P0,
  input  logic [31:0]                   data_write_P0,
  output logic [31:0]                   data_read_P0,
  output logic                          valid_P0,
  output logic                          err_P0,
  input  logic                          re_P1,
  input  logic                          we_P1,
  input  logic [31:0]                   addr_P1,
  input  logic [31:0]                   data_write_P1,
  output logic [31:0]                   data_read_P1,
  output logic                          valid_P1,
  output logic                          err_P1,
  output logic [USER_ADDRESS_WIDTH-1:0] addr_SDRAM,
  output logic                          re_SDRAM,
  output logic                          we_SDRAM,
  output logic [15:0]                   data_write_SDRAM,
  input  logic [15:0]                   data_read_SDRAM,
  input  logic                          valid_SDRAM,
  input  logic                          done_SDRAM
);
  localparam int UAW = USER_ADDRESS_WIDTH;
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ARB, LO, HI, RESP} state_t;
  state_t state_reg, state_next;

  logic            strobe_reg, strobe_next;
  logic            latch;
  logic [CW-1:0]   cnt_reg;
  logic            grant_reg;
  logic            wr_reg;
  logic [UAW-2:0]  word_reg;
  logic [31:0]     wdata_reg;
  logic [15:0]     rd_lo_reg;
  logic [UAW-1:0]  addr_reg;
  logic [15:0]     wd_reg;
  logic [31:0]     rd0_reg, rd1_reg;
  logic            v0_reg, v1_reg, e0_reg, e1_reg;

  logic req0, req1, pick1, complete, expire;
  logic [UAW-2:0] win_word;
  logic [31:0]    win_wdata;
  logic           win_we;
  logic           unused_addr;

  assign req0 = re_P0 | we_P0;
  assign req1 = re_P1 | we_P1;

`ifdef SDRAM_ARB_RR_EN
  // last_reg = 1 means P1 held the previous grant, so P0 wins the next tie.
  logic last_reg;
  assign pick1 = req1 & (~req0 | ~last_reg);
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_reg <= 1'b1;
    else if (latch)
      last_reg <= pick1;
  end
`else
  assign pick1 = req1 & ~req0;
`endif

  assign win_word  = pick1 ? addr_P1[UAW:2] : addr_P0[UAW:2];
  assign win_wdata = pick1 ? data_write_P1 : data_write_P0;
  assign win_we    = pick1 ? we_P1 : we_P0;
  assign unused_addr = ^{addr_P0[31:UAW+1], addr_P0[1:0], addr_P1[31:UAW+1], addr_P1[1:0]};

  // Completion only counts while a strobe is up, and only of the matching type.
  assign complete = strobe_reg & (wr_reg ? done_SDRAM : valid_SDRAM);
  assign expire   = strobe_reg & ~complete & (cnt_reg == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next  = state_reg;
    strobe_next = strobe_reg;
    latch       = 1'b0;
    case (state_reg)
      IDLE: if (req0 | req1) state_next = ARB;
      ARB: begin
        if (req0 | req1) begin
          latch       = 1'b1;
          state_next  = LO;
          strobe_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      LO: begin
        if (complete) begin
          state_next  = HI;
          strobe_next = 1'b0;
        end else if (expire) begin
          state_next  = RESP;
          strobe_next = 1'b0;
        end
      end
      HI: begin
        // First HI cycle is the mandatory strobe-low gap.
        if (!strobe_reg) begin
          strobe_next = 1'b1;
        end else if (complete || expire) begin
          state_next  = RESP;
          strobe_next = 1'b0;
        end
      end
      RESP: state_next = IDLE;
      default: begin
        state_next  = IDLE;
        strobe_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      strobe_reg <= 1'b0;
      cnt_reg    <= '0;
      grant_reg  <= 1'b0;
      wr_reg     <= 1'b0;
      word_reg   <= '0;
      wdata_reg  <= '0;
      rd_lo_reg  <= '0;
      addr_reg   <= '0;
      wd_reg     <= '0;
      rd0_reg    <= '0;
      rd1_reg    <= '0;
      v0_reg     <= 1'b0;
      v1_reg     <= 1'b0;
      e0_reg     <= 1'b0;
      e1_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= strobe_next;
      cnt_reg    <= (strobe_reg & strobe_next) ? cnt_reg + 1'b1 : '0;
      v0_reg     <= 1'b0;
      v1_reg     <= 1'b0;
      e0_reg     <= 1'b0;
      e1_reg     <= 1'b0;
      if (latch) begin
        grant_reg <= pick1;
        wr_reg    <= win_we;
        word_reg  <= win_word;
        wdata_reg <= win_wdata;
        addr_reg  <= {win_word, 1'b0};
        wd_reg    <= win_wdata[15:0];
      end
      if (state_reg == LO && complete) begin
        rd_lo_reg <= data_read_SDRAM;
        addr_reg  <= {word_reg, 1'b1};
        wd_reg    <= wdata_reg[31:16];
      end
      if (state_reg == HI && complete && !wr_reg) begin
        if (grant_reg)
          rd1_reg <= {data_read_SDRAM, rd_lo_reg};
        else
          rd0_reg <= {data_read_SDRAM, rd_lo_reg};
      end
      // Entering RESP without a completion means the access timed out.
      if (state_next == RESP) begin
        v0_reg <= ~grant_reg;
        v1_reg <= grant_reg;
        e0_reg <= ~grant_reg & ~complete;
        e1_reg <= grant_reg & ~complete;
      end
    end
  end

  assign re_SDRAM         = strobe_reg & ~wr_reg;
  assign we_SDRAM         = strobe_reg & wr_reg;
  assign addr_SDRAM       = addr_reg;
  assign data_write_SDRAM = wd_reg;
  assign data_read_P0     = rd0_reg;
  assign data_read_P1     = rd1_reg;
  assign valid_P0         = v0_reg;
  assign valid_P1         = v1_reg;
  assign err_P0           = e0_reg;
  assign err_P1           = e1_reg;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: write/read halfword sequencing, arbitration order, timeout, mid-transfer reset.
module tb_sdram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        re_P0, we_P0, re_P1, we_P1;
  logic [31:0] addr_P0, data_write_P0, addr_P1, data_write_P1;
  logic [31:0] data_read_P0, data_read_P1;
  logic        valid_P0, err_P0, valid_P1, err_P1;
  logic [23:0] addr_SDRAM;
  logic        re_SDRAM, we_SDRAM;
  logic [15:0] data_write_SDRAM, data_read_SDRAM;
  logic        valid_SDRAM, done_SDRAM;

  int errors = 0;
  int checks = 0;

  sdram_arbiter #(.TIMEOUT_CYC(16), .USER_ADDRESS_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .re_P0(re_P0), .we_P0(we_P0), .addr_P0(addr_P0), .data_write_P0(data_write_P0),
    .data_read_P0(data_read_P0), .valid_P0(valid_P0), .err_P0(err_P0),
    .re_P1(re_P1), .we_P1(we_P1), .addr_P1(addr_P1), .data_write_P1(data_write_P1),
    .data_read_P1(data_read_P1), .valid_P1(valid_P1), .err_P1(err_P1),
    .addr_SDRAM(addr_SDRAM), .re_SDRAM(re_SDRAM), .we_SDRAM(we_SDRAM),
    .data_write_SDRAM(data_write_SDRAM), .data_read_SDRAM(data_read_SDRAM),
    .valid_SDRAM(valid_SDRAM), .done_SDRAM(done_SDRAM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Acts as the SDRAM controller for one halfword access; returns on the cycle after completion.
  task automatic serve_half(input string tag, input logic exp_we, input logic [23:0] exp_addr,
                            input logic [15:0] exp_wd, input logic [15:0] rdata,
                            input int delay, input logic spurious);
    int n = 0;
    while (!(re_SDRAM | we_SDRAM) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " strobe seen"}, 32'(n < 40), 32'd1);
    chk({tag, " we"}, 32'(we_SDRAM), 32'(exp_we));
    chk({tag, " re"}, 32'(re_SDRAM), 32'(!exp_we));
    chk({tag, " addr"}, 32'(addr_SDRAM), 32'(exp_addr));
    if (exp_we) chk({tag, " wdata"}, 32'(data_write_SDRAM), 32'(exp_wd));
    if (spurious) begin
      if (exp_we) valid_SDRAM = 1'b1; else done_SDRAM = 1'b1;
      @(negedge clk);
      valid_SDRAM = 1'b0;
      done_SDRAM  = 1'b0;
      @(negedge clk);
      chk({tag, " ignore wrong completion"}, 32'(re_SDRAM | we_SDRAM), 32'd1);
    end
    repeat (delay) @(negedge clk);
    chk({tag, " addr held"}, 32'(addr_SDRAM), 32'(exp_addr));
    data_read_SDRAM = rdata;
    if (exp_we) done_SDRAM = 1'b1; else valid_SDRAM = 1'b1;
    @(negedge clk);
    valid_SDRAM = 1'b0;
    done_SDRAM  = 1'b0;
    chk({tag, " strobe drop"}, 32'(re_SDRAM | we_SDRAM), 32'd0);
  endtask

  initial begin
    logic        rr;
    logic        exp1;
    logic [31:0] hold;
    int          cnt;
    int          pulses;
`ifdef SDRAM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_n = 1'b0;
    re_P0 = 0; we_P0 = 0; re_P1 = 0; we_P1 = 0;
    addr_P0 = 0; addr_P1 = 0; data_write_P0 = 0; data_write_P1 = 0;
    data_read_SDRAM = 0; valid_SDRAM = 0; done_SDRAM = 0;
    repeat (3) @(negedge clk);
    chk("rst re_SDRAM", 32'(re_SDRAM), 0);
    chk("rst we_SDRAM", 32'(we_SDRAM), 0);
    chk("rst addr_SDRAM", 32'(addr_SDRAM), 0);
    chk("rst data_write_SDRAM", 32'(data_write_SDRAM), 0);
    chk("rst valid", 32'({valid_P0, valid_P1, err_P0, err_P1}), 0);
    chk("rst data_read_P0", data_read_P0, 0);
    chk("rst data_read_P1", data_read_P1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // P0 write 0x12345678 at 0x0; inputs scrambled after the grant must not matter.
    we_P0 = 1; addr_P0 = 32'h0; data_write_P0 = 32'h12345678;
    serve_half("wr lo", 1'b1, 24'h0, 16'h5678, 16'h0, 2, 1'b1);
    addr_P0 = 32'h0000FFFC; data_write_P0 = 32'h0;
    serve_half("wr hi", 1'b1, 24'h1, 16'h1234, 16'h0, 1, 1'b0);
    chk("wr valid_P0", 32'(valid_P0), 1);
    chk("wr valid_P1", 32'(valid_P1), 0);
    chk("wr err_P0", 32'(err_P0), 0);
    we_P0 = 0;
    @(negedge clk);
    chk("wr valid_P0 one cycle", 32'(valid_P0), 0);
    chk("wr no read update", data_read_P0, 0);
    $display("txn P0 write 0x12345678 @0x0 done");

    // P1 read 0x8; requester drops mid-transfer yet still gets its pulse.
    re_P1 = 1; addr_P1 = 32'h8;
    serve_half("rd lo", 1'b0, 24'h4, 16'h0, 16'hBEEF, 0, 1'b1);
    re_P1 = 0;
    serve_half("rd hi", 1'b0, 24'h5, 16'h0, 16'hDEAD, 3, 1'b0);
    chk("rd valid_P1", 32'(valid_P1), 1);
    chk("rd valid_P0", 32'(valid_P0), 0);
    chk("rd data_read_P1", data_read_P1, 32'hDEADBEEF);
    chk("rd err_P1", 32'(err_P1), 0);
    @(negedge clk);
    chk("rd valid_P1 one cycle", 32'(valid_P1), 0);
    chk("rd data hold", data_read_P1, 32'hDEADBEEF);
    $display("txn P1 read @0x8 -> %h", data_read_P1);

    // Both ports request continuously for four grants.
    re_P0 = 1; addr_P0 = 32'h10; re_P1 = 1; addr_P1 = 32'h20;
    for (int k = 0; k < 4; k++) begin
      exp1 = rr & k[0];
      serve_half("arb lo", 1'b0, exp1 ? 24'd16 : 24'd8, 16'h0, 16'(16'h1000 + k), 1, 1'b0);
      serve_half("arb hi", 1'b0, exp1 ? 24'd17 : 24'd9, 16'h0, 16'(16'h2000 + k), 0, 1'b0);
      chk("arb valid_P0", 32'(valid_P0), 32'(!exp1));
      chk("arb valid_P1", 32'(valid_P1), 32'(exp1));
      chk("arb data", exp1 ? data_read_P1 : data_read_P0,
          {16'(16'h2000 + k), 16'(16'h1000 + k)});
      $display("txn contention %0d granted P%0d", k, exp1);
    end
    re_P0 = 0; re_P1 = 0;
    repeat (2) @(negedge clk);

    // Timeout with TIMEOUT_CYC = 16: no valid_SDRAM ever arrives.
    hold = rr ? 32'h20021002 : 32'h20031003;
    re_P0 = 1; addr_P0 = 32'h30;
    cnt = 0;
    while (!re_SDRAM && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("to strobe seen", 32'(cnt < 40), 1);
    chk("to addr", 32'(addr_SDRAM), 32'h18);
    cnt = 0;
    while (re_SDRAM && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("to strobe cycles", 32'(cnt), 16);
    chk("to valid_P0", 32'(valid_P0), 1);
    chk("to err_P0", 32'(err_P0), 1);
    chk("to data unchanged", data_read_P0, hold);
    re_P0 = 0;
    @(negedge clk);
    chk("to pulse end", 32'({valid_P0, err_P0}), 0);
    $display("txn P0 read @0x30 timed out after %0d cycles", cnt);

    // Reset during the HI access of a P1 write.
    we_P1 = 1; addr_P1 = 32'h40; data_write_P1 = 32'hCAFEF00D;
    serve_half("rst lo", 1'b1, 24'h20, 16'hF00D, 16'h0, 0, 1'b0);
    @(negedge clk);
    chk("rst hi we", 32'(we_SDRAM), 1);
    chk("rst hi addr", 32'(addr_SDRAM), 32'h21);
    chk("rst hi wdata", 32'(data_write_SDRAM), 32'hCAFE);
    rst_n = 0; we_P1 = 0;
    @(negedge clk);
    chk("mid rst strobes", 32'({re_SDRAM, we_SDRAM}), 0);
    chk("mid rst addr", 32'(addr_SDRAM), 0);
    chk("mid rst data_read_P1", data_read_P1, 0);
    rst_n = 1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid_P0 || valid_P1 || re_SDRAM || we_SDRAM) pulses++;
    end
    chk("mid rst quiet", 32'(pulses), 0);
    re_P0 = 1; addr_P0 = 32'h4;
    serve_half("post lo", 1'b0, 24'h2, 16'h0, 16'h3333, 1, 1'b0);
    serve_half("post hi", 1'b0, 24'h3, 16'h0, 16'h4444, 1, 1'b0);
    chk("post valid_P0", 32'(valid_P0), 1);
    chk("post data", data_read_P0, 32'h44443333);
    re_P0 = 0;
    @(negedge clk);
    $display("txn reset mid-write, then P0 read @0x4 -> %h", data_read_P0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
